// File: rtl/cm_bus_pkg.sv
// Shared types and constants for the CM strobe-bus initiator.
package cm_bus_pkg;

    localparam int CM_WIDTH           = 8;
    localparam int CM_MIN_HALF_PERIOD = 2;
    localparam int CM_MIN_TURNAROUND  = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_HOLD,
        ST_TURN
    } cm_state_t;

    function automatic int cm_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cm_phase_timer.sv
// Loadable down-counter; done marks the last cycle of a phase.
module cm_phase_timer #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == CW'(1));

endmodule

// File: rtl/cm_bus_master.sv
// CM strobe-bus initiator: setup/high/hold strobe for writes, turnaround reads.
// Optional strobe timestamp port enabled by CM_MASTER_TS_EN.
module cm_bus_master
    import cm_bus_pkg::*;
#(
    parameter int HALF_PERIOD = 4,
    parameter int TURNAROUND  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tx_valid,
    output logic                tx_ready,
    input  logic                tx_rd,
    input  logic [CM_WIDTH-1:0] tx_data,
    output logic                rx_valid,
    output logic [CM_WIDTH-1:0] rx_data,
    output logic [CM_WIDTH-1:0] cm_out,
    output logic                cm_oe,
    input  logic [CM_WIDTH-1:0] cm_in,
    output logic                clk_inter
`ifdef CM_MASTER_TS_EN
    ,
    output logic [31:0]         ts
`endif
);

    localparam int CW = $clog2(cm_max(HALF_PERIOD, TURNAROUND) + 1);
    localparam logic [CW-1:0] HP_L = CW'(HALF_PERIOD);
    localparam logic [CW-1:0] TA_L = CW'(TURNAROUND);

    if (HALF_PERIOD < CM_MIN_HALF_PERIOD || TURNAROUND < CM_MIN_TURNAROUND) begin : g_bad_param
        $fatal(1, "cm_bus_master: HALF_PERIOD or TURNAROUND below minimum");
    end

    cm_state_t state_q, state_d;
    logic                rd_q, rd_d;
    logic                ready_q, ready_d;
    logic                oe_q, oe_d;
    logic                ci_q, ci_d;
    logic                rxv_q, rxv_d;
    logic [CM_WIDTH-1:0] out_q, out_d;
    logic [CM_WIDTH-1:0] rxd_q, rxd_d;
    logic                load;
    logic [CW-1:0]       load_val;
    logic                done;

    cm_phase_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .done     (done)
    );

    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        ready_d  = ready_q;
        oe_d     = oe_q;
        ci_d     = ci_q;
        rxv_d    = 1'b0;
        out_d    = out_q;
        rxd_d    = rxd_q;
        load     = 1'b0;
        load_val = HP_L;
        unique case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    rd_d    = tx_rd;
                    ready_d = 1'b0;
                    load    = 1'b1;
                    if (tx_rd) begin
                        state_d  = ST_TURN;
                        load_val = TA_L;
                        oe_d     = 1'b0;
                    end else begin
                        state_d = ST_SETUP;
                        oe_d    = 1'b1;
                        out_d   = tx_data;
                    end
                end
            end
            ST_SETUP, ST_TURN: begin
                if (done) begin
                    state_d = ST_HIGH;
                    load    = 1'b1;
                    ci_d    = 1'b1;
                end
            end
            ST_HIGH: begin
                if (done) begin
                    state_d  = ST_HOLD;
                    load     = 1'b1;
                    load_val = rd_q ? TA_L : HP_L;
                    ci_d     = 1'b0;
                    // Reads sample the bus at the close of the high phase
                    if (rd_q) begin
                        rxd_d = cm_in;
                        rxv_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (done) begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                oe_d    = 1'b0;
                ci_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rd_q    <= 1'b0;
            ready_q <= 1'b1;
            oe_q    <= 1'b0;
            ci_q    <= 1'b0;
            rxv_q   <= 1'b0;
            out_q   <= '0;
            rxd_q   <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            ready_q <= ready_d;
            oe_q    <= oe_d;
            ci_q    <= ci_d;
            rxv_q   <= rxv_d;
            out_q   <= out_d;
            rxd_q   <= rxd_d;
        end
    end

    assign tx_ready  = ready_q;
    assign rx_valid  = rxv_q;
    assign rx_data   = rxd_q;
    assign cm_out    = out_q;
    assign cm_oe     = oe_q;
    assign clk_inter = ci_q;

`ifdef CM_MASTER_TS_EN
    logic [31:0] free_q, free_d;
    logic [31:0] ts_q, ts_d;

    always_comb begin
        free_d = free_q + 32'd1;
        ts_d   = ts_q;
        if (ci_d && !ci_q) begin
            ts_d = free_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            free_q <= '0;
            ts_q   <= '0;
        end else begin
            free_q <= free_d;
            ts_q   <= ts_d;
        end
    end

    assign ts = ts_q;
`endif

endmodule

// File: tb/tb_cm_bus_master.sv
// Self-checking bench for cm_bus_master: vector table, scoreboard, corner sequences.
module tb_cm_bus_master;

    localparam int HP = 4;
    localparam int TA = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_rd;
    logic [7:0] tx_data;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [7:0] cm_out;
    logic       cm_oe;
    logic [7:0] cm_in;
    logic       clk_inter;
`ifdef CM_MASTER_TS_EN
    logic [31:0] ts;
`endif

    cm_bus_master #(.HALF_PERIOD(HP), .TURNAROUND(TA)) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_rd     (tx_rd),
        .tx_data   (tx_data),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .cm_out    (cm_out),
        .cm_oe     (cm_oe),
        .cm_in     (cm_in),
        .clk_inter (clk_inter)
`ifdef CM_MASTER_TS_EN
        ,
        .ts        (ts)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] wr_q[$];
    logic [7:0] rd_q[$];
    int  rises = 0;
    int  rel_cnt = 0;
    int  last_gap = 0;
    logic prev_ci = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: write data checked at each strobe rise, read data at rx_valid
    always @(negedge clk) begin
        if (clk_inter && !prev_ci) begin
            rises++;
            if (cm_oe) begin
                if (wr_q.size() == 0) chk("wr_unexpected", {31'd0, clk_inter}, 32'd0);
                else chk("wr_data", {24'd0, cm_out}, {24'd0, wr_q.pop_front()});
            end else begin
                last_gap = rel_cnt;
            end
        end
        if (rx_valid) begin
            if (rd_q.size() == 0) chk("rx_unexpected", {31'd0, rx_valid}, 32'd0);
            else chk("rd_data", {24'd0, rx_data}, {24'd0, rd_q.pop_front()});
        end
        rel_cnt = cm_oe ? 0 : rel_cnt + 1;
        prev_ci = clk_inter;
    end

    typedef struct {
        bit         rd;
        logic [7:0] data;
        logic [7:0] cin;
        logic [7:0] cin_late;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[6];
    logic [7:0] last_rd;

    task automatic wait_ready();
        int n = 0;
        while (!tx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) chk("ready_timeout", {31'd0, tx_ready}, 32'd1);
    endtask

    task automatic run_txn(input bit rd, input logic [7:0] d, input logic [7:0] cin,
                           input logic [7:0] cin_late, input logic [7:0] exp, input int rst_at);
        int len;
        bit oe_e, ci_e, rv_e, rdy_e;
        wait_ready();
        tx_valid = 1'b1;
        tx_rd    = rd;
        tx_data  = d;
        cm_in    = cin;
        @(posedge clk);
        if (!(rd && rst_at != 0)) begin
            if (rd) rd_q.push_back(exp);
            else wr_q.push_back(exp);
        end
        len = rd ? 2 * TA + HP : 3 * HP;
        for (int k = 1; k <= len + 1; k++) begin
            @(negedge clk);
            if (k == 1) tx_valid = 1'b0;
            if (rd) begin
                oe_e = 1'b0;
                ci_e = (k > TA) && (k <= TA + HP);
                rv_e = (k == TA + HP + 1);
            end else begin
                oe_e = (k <= len);
                ci_e = (k > HP) && (k <= 2 * HP);
                rv_e = 1'b0;
            end
            rdy_e = (k == len + 1);
            chk("cm_oe", {31'd0, cm_oe}, {31'd0, oe_e});
            chk("clk_inter", {31'd0, clk_inter}, {31'd0, ci_e});
            chk("rx_valid", {31'd0, rx_valid}, {31'd0, rv_e});
            chk("tx_ready", {31'd0, tx_ready}, {31'd0, rdy_e});
            if (!rd && k <= len) chk("cm_out", {24'd0, cm_out}, {24'd0, d});
            if (rd && k == TA + HP) cm_in = cin_late;
            if (rst_at != 0 && k == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                chk("rst_clk_inter", {31'd0, clk_inter}, 32'd0);
                chk("rst_cm_oe", {31'd0, cm_oe}, 32'd0);
                chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
                chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
                rst = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_rd    = 1'b0;
        tx_data  = 8'h00;
        cm_in    = 8'h00;
        last_rd  = 8'h00;

        vecs[0] = '{rd: 1'b0, data: 8'hA5, cin: 8'h00, cin_late: 8'h00, exp: 8'hA5};
        vecs[1] = '{rd: 1'b1, data: 8'h00, cin: 8'h3C, cin_late: 8'h3C, exp: 8'h3C};
        vecs[2] = '{rd: 1'b0, data: 8'hFF, cin: 8'h00, cin_late: 8'h00, exp: 8'hFF};
        vecs[3] = '{rd: 1'b1, data: 8'h12, cin: 8'hC3, cin_late: 8'hC3, exp: 8'hC3};
        vecs[4] = '{rd: 1'b0, data: 8'h00, cin: 8'hFF, cin_late: 8'hFF, exp: 8'h00};
        vecs[5] = '{rd: 1'b1, data: 8'h00, cin: 8'h55, cin_late: 8'hAA, exp: 8'hAA};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("rst_cm_out", {24'd0, cm_out}, 32'd0);
        chk("rst_cm_oe", {31'd0, cm_oe}, 32'd0);
        chk("rst_clk_inter", {31'd0, clk_inter}, 32'd0);

        // Request presented while reset is still sampled high is dropped
        tx_valid = 1'b1;
        tx_data  = 8'hEE;
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        tx_valid = 1'b0;
        chk("rstval_ready", {31'd0, tx_ready}, 32'd1);
        chk("rstval_oe", {31'd0, cm_oe}, 32'd0);
        repeat (2) @(negedge clk);
        chk("rstval_noop", {31'd0, cm_oe | clk_inter}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].rd, vecs[i].data, vecs[i].cin, vecs[i].cin_late, vecs[i].exp, 0);
            if (vecs[i].rd) last_rd = vecs[i].exp;
            chk("rx_hold", {24'd0, rx_data}, {24'd0, last_rd});
        end

        // Held tx_valid: second request only accepted once ready returns
        begin
            int r0;
            wait_ready();
            r0 = rises;
            tx_valid = 1'b1;
            tx_rd    = 1'b0;
            tx_data  = 8'h5A;
            @(posedge clk);
            wr_q.push_back(8'h5A);
            @(negedge clk);
            tx_data = 8'hC3;
            for (int k = 1; k <= 13; k++) begin
                if (k > 1) @(negedge clk);
                chk("held_ready", {31'd0, tx_ready}, {31'd0, k == 13});
            end
            @(posedge clk);
            wr_q.push_back(8'hC3);
            @(negedge clk);
            tx_valid = 1'b0;
            chk("held_second_oe", {31'd0, cm_oe}, 32'd1);
            chk("held_second_out", {24'd0, cm_out}, 32'h0000_00C3);
            chk("held_second_ready", {31'd0, tx_ready}, 32'd0);
            repeat (3 * HP + 2) @(negedge clk);
            chk("held_strobes", rises - r0, 32'd2);
        end

        run_txn(1'b0, 8'h96, 8'h00, 8'h00, 8'h96, 6);
        last_rd = 8'h00;
        chk("rst_wr_rx_data", {24'd0, rx_data}, 32'd0);
        run_txn(1'b1, 8'h00, 8'h77, 8'h77, 8'h77, 5);
        repeat (2 * TA + HP) @(negedge clk);
        chk("rst_rd_quiet", {31'd0, rx_valid}, 32'd0);

        run_txn(1'b0, 8'h81, 8'h00, 8'h00, 8'h81, 0);
        run_txn(1'b1, 8'h00, 8'h42, 8'h42, 8'h42, 0);
        chk("b2b_released", {31'd0, last_gap >= TA}, 32'd1);

`ifdef CM_MASTER_TS_EN
        begin
            logic [31:0] ts_a;
            wait_ready();
            tx_valid = 1'b1;
            tx_rd    = 1'b0;
            tx_data  = 8'h11;
            @(posedge clk);
            wr_q.push_back(8'h11);
            @(negedge clk);
            tx_valid = 1'b0;
            repeat (20) @(negedge clk);
            ts_a = ts;
            repeat (79) @(negedge clk);
            tx_valid = 1'b1;
            tx_data  = 8'h22;
            @(posedge clk);
            wr_q.push_back(8'h22);
            @(negedge clk);
            tx_valid = 1'b0;
            repeat (20) @(negedge clk);
            chk("ts_delta", ts - ts_a, 32'd100);
            force dut.free_q = 32'hFFFF_FFF0;
            @(posedge clk);
            @(negedge clk);
            release dut.free_q;
            repeat (20) @(negedge clk);
            tx_valid = 1'b1;
            tx_data  = 8'h33;
            @(posedge clk);
            wr_q.push_back(8'h33);
            @(negedge clk);
            tx_valid = 1'b0;
            repeat (20) @(negedge clk);
            chk("ts_wrap", {31'd0, ts < 32'd64}, 32'd1);
        end
`endif

        repeat (4) @(negedge clk);
        chk("wr_sb_empty", wr_q.size(), 32'd0);
        chk("rd_sb_empty", rd_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
